wetdry_mix_n: RTL and testbench

//  N-channel wet/dry crossfader with a slewed gain and an output mode select.

---
 rtl/wetdry_mix_n.sv | 161 ++++++++++++++++
 tb/tb_wetdry_mix_n.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/wetdry_mix_n.sv
// N-channel wet/dry crossfader. A single signed MAC is time-shared over the
// channels of each frame; the wet gain slews toward the pot setting by at most
// STEP per accepted frame to avoid zipper noise. All channel results are
// presented together with a one-cycle valid pulse.
module wetdry_mix_n #(
  parameter int DW   = 16,
  parameter int GW   = 12,
  parameter int NCH  = 2,
  parameter int STEP = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ena_i,
  input  logic [GW-1:0]     pot_i,
  input  logic [1:0]        mode_i,
  input  logic [NCH*DW-1:0] dry_i,
  input  logic [NCH*DW-1:0] wet_i,
  output logic [NCH*DW-1:0] out_o,
  output logic              valid_o,
  output logic              busy_o,
  output logic              ovr_o
);

  localparam int PW = DW + GW + 1;
  localparam int AW = DW + GW + 2;
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic signed [AW-1:0] RND    = AW'(1 << (GW - 1));
  localparam logic signed [AW-1:0] SMAX   = AW'((1 << (DW - 1)) - 1);
  localparam logic signed [AW-1:0] SMIN   = ~SMAX;
  localparam logic signed [GW:0]   STEP_S = (GW + 1)'(STEP);

  typedef enum logic [2:0] {S_IDLE, S_MDRY, S_MWET, S_ACC, S_STORE, S_DONE} state_t;

  state_t                   state_q;
  logic [CW-1:0]            ch_q;
  logic [GW-1:0]            gain_q, gain_d;
  logic [1:0]               mode_q;
  logic [NCH*DW-1:0]        dry_q, wet_q, res_q, out_q;
  logic                     valid_q, ovr_q;
  logic signed [PW-1:0]     prod_q;
  logic signed [AW-1:0]     acc_q;
  logic signed [DW-1:0]     dry_ch, wet_ch, store_val;
  logic signed [GW:0]       g_s, ig_s, diff;
  logic                     accept;

  // Full-precision signed multiply; operands widened so the product is exact.
  function automatic logic signed [PW-1:0] mul(input logic signed [DW-1:0] s,
                                               input logic signed [GW:0]   k);
    logic signed [PW-1:0] se, ke;
    se = PW'(s);
    ke = PW'(k);
    return se * ke;
  endfunction

  // Round half up, drop the gain fraction bits, clamp to the sample range.
  function automatic logic signed [DW-1:0] sat(input logic signed [AW-1:0] x);
    logic signed [AW-1:0] r;
    r = (x + RND) >>> GW;
    if (r > SMAX)      return SMAX[DW-1:0];
    else if (r < SMIN) return SMIN[DW-1:0];
    else               return r[DW-1:0];
  endfunction

  assign accept  = ena_i && (state_q == S_IDLE);
  assign g_s     = signed'({1'b0, gain_q});
  assign ig_s    = signed'({1'b0, ~gain_q});
  assign busy_o  = (state_q != S_IDLE);
  assign out_o   = out_q;
  assign valid_o = valid_q;
  assign ovr_o   = ovr_q;

  // Gain slew: jump to the pot when within STEP, otherwise move by STEP.
  always_comb begin
    diff = signed'({1'b0, pot_i}) - signed'({1'b0, gain_q});
    if (diff > STEP_S)       gain_d = gain_q + GW'(STEP);
    else if (diff < -STEP_S) gain_d = gain_q - GW'(STEP);
    else                     gain_d = pot_i;
  end

  // Select the current channel's latched samples and the value to store.
  always_comb begin
    dry_ch = '0;
    wet_ch = '0;
    for (int c = 0; c < NCH; c++) begin
      if (CW'(c) == ch_q) begin
        dry_ch = dry_q[c*DW +: DW];
        wet_ch = wet_q[c*DW +: DW];
      end
    end
    case (mode_q)
      2'b01:   store_val = dry_ch;
      2'b10:   store_val = wet_ch;
      2'b11:   store_val = '0;
      default: store_val = sat(acc_q);
    endcase
  end

  // Control: sequencer, channel counter, gain, overrun flag and output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      ch_q    <= '0;
      gain_q  <= '0;
      ovr_q   <= 1'b0;
      valid_q <= 1'b0;
      out_q   <= '0;
    end else begin
      valid_q <= 1'b0;
      if (ena_i && state_q != S_IDLE) ovr_q <= 1'b1;
      case (state_q)
        S_IDLE: if (accept) begin
          gain_q  <= gain_d;
          state_q <= S_MDRY;
        end
        S_MDRY:  state_q <= S_MWET;
        S_MWET:  state_q <= S_ACC;
        S_ACC:   state_q <= S_STORE;
        S_STORE: begin
          if (ch_q == CW'(NCH - 1)) begin
            state_q <= S_DONE;
          end else begin
            ch_q    <= ch_q + 1'b1;
            state_q <= S_MDRY;
          end
        end
        S_DONE: begin
          out_q   <= res_q;
          valid_q <= 1'b1;
          ch_q    <= '0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Datapath: frame latch, MAC steps and per-channel result store.
  always_ff @(posedge clk) begin
    if (accept) begin
      dry_q  <= dry_i;
      wet_q  <= wet_i;
      mode_q <= mode_i;
    end
    case (state_q)
      S_MDRY: prod_q <= mul(dry_ch, ig_s);
      S_MWET: begin
        acc_q  <= AW'(prod_q);
        prod_q <= mul(wet_ch, g_s);
      end
      S_ACC:  acc_q <= acc_q + AW'(prod_q);
      S_STORE: begin
        for (int c = 0; c < NCH; c++) begin
          if (CW'(c) == ch_q) res_q[c*DW +: DW] <= store_val;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wetdry_mix_n.sv
// Bench for wetdry_mix_n (NCH=2): vector table, directed corner sequences and
// randomized frames against an arithmetic reference model.
module tb_wetdry_mix_n;
  localparam int DW = 16, GW = 12, NCH = 2, STEP = 256;
  localparam int LAT = 4 * NCH + 1;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              ena_i = 1'b0;
  logic [GW-1:0]     pot_i = '0;
  logic [1:0]        mode_i = '0;
  logic [NCH*DW-1:0] dry_i = '0, wet_i = '0;
  logic [NCH*DW-1:0] out_o;
  logic              valid_o, busy_o, ovr_o;

  int checks = 0;
  int failures = 0;
  int gain_m = 0;

  wetdry_mix_n #(.DW(DW), .GW(GW), .NCH(NCH), .STEP(STEP)) dut (
    .clk(clk), .reset(reset), .ena_i(ena_i), .pot_i(pot_i), .mode_i(mode_i),
    .dry_i(dry_i), .wet_i(wet_i), .out_o(out_o), .valid_o(valid_o),
    .busy_o(busy_o), .ovr_o(ovr_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int d0, d1, w0, w1, pot, mode, e0, e1;
  } vec_t;
  vec_t tbl[5];

  task automatic chk(input string nm, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  function automatic int slew(input int g, input int p);
    int df;
    df = p - g;
    if (df > STEP)  return g + STEP;
    if (df < -STEP) return g - STEP;
    return p;
  endfunction

  function automatic int mix_ref(input int d, input int w, input int g, input int m);
    longint s, r, full, lo, hi;
    if (m == 1) return d;
    if (m == 2) return w;
    if (m == 3) return 0;
    full = (longint'(1) << GW) - 1;
    s = longint'(d) * (full - g) + longint'(w) * g;
    r = (s + (longint'(1) << (GW - 1))) >>> GW;
    hi = (longint'(1) << (DW - 1)) - 1;
    lo = -hi - 1;
    if (r > hi) r = hi;
    if (r < lo) r = lo;
    return int'(r);
  endfunction

  function automatic int chan(input int c);
    logic signed [DW-1:0] t;
    t = out_o[c*DW +: DW];
    return int'(t);
  endfunction

  // One frame: drive, accept, optionally poke ena at clock 'inj', await valid.
  task automatic run_frame(input int d0, input int d1, input int w0, input int w1,
                           input int p, input int m, input int inj,
                           output int o0, output int o1);
    int n;
    bit seen;
    @(negedge clk);
    dry_i  = {DW'(d1), DW'(d0)};
    wet_i  = {DW'(w1), DW'(w0)};
    pot_i  = GW'(p);
    mode_i = 2'(m);
    ena_i  = 1'b1;
    @(posedge clk);
    #1;
    ena_i = 1'b0;
    gain_m = slew(gain_m, p);
    chk("busy_after_accept", busy_o, 1);
    // Later input changes must not reach this frame.
    dry_i = ~dry_i;
    wet_i = ~wet_i;
    mode_i = ~mode_i;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 30) begin
      @(posedge clk);
      #1;
      n++;
      ena_i = (n == inj);
      if (valid_o) seen = 1'b1;
    end
    ena_i = 1'b0;
    chk("latency", seen ? n : -1, LAT);
    o0 = chan(0);
    o1 = chan(1);
    chk("out_ch0_model", o0, mix_ref(d0, w0, gain_m, m));
    chk("out_ch1_model", o1, mix_ref(d1, w1, gain_m, m));
    @(posedge clk);
    #1;
    chk("valid_one_cycle", valid_o, 0);
  endtask

  initial begin
    int o0, o1, p0, p1, k, bad;
    tbl[0] = '{500, 1000, -1000, -1000, 0, 0, 500, 1000};
    tbl[1] = '{1234, 1234, -4321, -4321, 0, 1, 1234, 1234};
    tbl[2] = '{1234, 1234, -4321, -4321, 0, 2, -4321, -4321};
    tbl[3] = '{1234, 1234, -4321, -4321, 0, 3, 0, 0};
    tbl[4] = '{-32768, 32767, 7, -7, 0, 0, -32760, 32759};

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_out", out_o, 0);
    chk("rst_valid", valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_ovr", ovr_o, 0);

    // Table vectors at settled gain 0, incl. mode overrides.
    for (int i = 0; i < 5; i++) begin
      run_frame(tbl[i].d0, tbl[i].d1, tbl[i].w0, tbl[i].w1, tbl[i].pot, tbl[i].mode, 0, o0, o1);
      chk($sformatf("tbl%0d_ch0", i), o0, tbl[i].e0);
      chk($sformatf("tbl%0d_ch1", i), o1, tbl[i].e1);
    end

    // Slew 0 -> 4095: output moves monotonically toward wet every frame.
    run_frame(-20000, 10000, 20000, -10000, 0, 0, 0, p0, p1);
    for (int f = 1; f <= 16; f++) begin
      run_frame(-20000, 10000, 20000, -10000, 4095, 0, 0, o0, o1);
      if (f < 16) chk($sformatf("slew_gain_f%0d", f), gain_m, 256 * f);
      chk($sformatf("mono_ch0_f%0d", f), (o0 > p0) ? 1 : 0, 1);
      chk($sformatf("mono_ch1_f%0d", f), (o1 < p1) ? 1 : 0, 1);
      p0 = o0;
      p1 = o1;
    end
    chk("slew_end_ch0", o0, 19995);
    chk("slew_end_ch1", o1, -9998);

    // Bring gain to 2048, then full-scale inputs must not wrap.
    k = 0;
    while (gain_m != 2048 && k < 12) begin
      run_frame(100, -100, 200, -200, 2048, 0, 0, o0, o1);
      k++;
    end
    chk("gain_2048_reached", gain_m, 2048);
    run_frame(-32768, 32767, -32768, 32767, 2048, 0, 0, o0, o1);
    chk("fs_neg", o0, -32760);
    chk("fs_pos", o1, 32759);
    run_frame(1234, 1234, -4321, -4321, 2048, 1, 0, o0, o1);
    chk("mode01_g2048", o0, 1234);

    // ena while busy: ignored, ovr sticky.
    run_frame(3000, -3000, -600, 600, 2048, 0, 3, o0, o1);
    chk("ovr_set", ovr_o, 1);
    run_frame(10, 20, 30, 40, 2048, 0, 0, o0, o1);
    chk("ovr_sticky", ovr_o, 1);

    // Randomized frames against the model.
    for (int r = 0; r < 24; r++) begin
      int rd0, rd1, rw0, rw1;
      logic signed [DW-1:0] t;
      t = DW'($urandom); rd0 = t;
      t = DW'($urandom); rd1 = t;
      t = DW'($urandom); rw0 = t;
      t = DW'($urandom); rw1 = t;
      run_frame(rd0, rd1, rw0, rw1, int'($urandom_range(0, 4095)),
                int'($urandom_range(0, 3)), 0, o0, o1);
    end

    // Reset in MWET of ch1 aborts the frame.
    run_frame(5000, 5000, 5000, 5000, 4095, 2, 0, o0, o1);
    @(negedge clk);
    dry_i = {DW'(777), DW'(777)};
    wet_i = dry_i;
    mode_i = 2'b00;
    ena_i = 1'b1;
    @(posedge clk);
    #1;
    ena_i = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    gain_m = 0;
    chk("abort_out", out_o, 0);
    chk("abort_busy", busy_o, 0);
    chk("abort_ovr", ovr_o, 0);
    bad = 0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk);
      #1;
      if (valid_o || out_o != 0) bad++;
    end
    chk("abort_no_valid", bad, 0);
    run_frame(500, 1000, -1000, -1000, 0, 0, 0, o0, o1);
    chk("post_abort_ch0", o0, 500);
    chk("post_abort_ch1", o1, 1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=%0d exp=%0d", 0, 1);
    $fatal(1, "timeout");
  end
endmodule
